spi_frame_writer: RTL

- Sits directly downstream of the SPI byte receiver. Consumes its writeData/writeEnable outputs and writes each received pixel byte into the frame buffer RAM in raster order.
- writeEnable originates in the spiClk domain, so this block synchronizes it into the system clock domain and detects its rising edge.
- Tracks row and column, flags frame completion to the edge-detection core, and holds off new pixels until that core acknowledges the frame.

---
 rtl/spi_frame_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_writer.sv
// -----------------------------------------------------------------------------
// spi_frame_writer
//
// Takes bytes from the SPI byte receiver and writes them into the frame buffer
// RAM in raster order. writeEnable comes from the spiClk domain, so it is
// synchronized into clk and rising-edge detected. Row, column and a running
// address counter track the position. A completed frame is flagged to the
// edge-detection core, and the buffer is held until that core acknowledges it.
//
// Optional feature: define FRAME_CHECKSUM_EN to add frameChecksum. This output
// is a modulo-2^messageBits sum of the pixels written in the current frame.
//
// Ports:
//   clk           system clock (only clock)
//   rst           synchronous active-high reset
//   writeData     byte from the SPI receiver, stable while writeEnable is high
//   writeEnable   byte-ready level, asynchronous to clk
//   frameAck      one-cycle pulse: frame consumed, buffer may be refilled
//   memWriteEn    frame buffer write strobe, one cycle per pixel
//   memAddr       frame buffer write address
//   memData       frame buffer write data
//   row / col     position of the next pixel to be written
//   frameDone     one-cycle pulse after the last pixel of a frame is written
//   frameFull     high while a complete frame awaits frameAck
//   overrunErr    sticky: a byte arrived while the frame was full
//   frameChecksum (FRAME_CHECKSUM_EN only) running pixel sum of the frame
// -----------------------------------------------------------------------------
module spi_frame_writer #(
  parameter int messageBits = 8,
  parameter int imgWidth    = 160,
  parameter int imgHeight   = 120,
  parameter int addrBits    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [messageBits-1:0]        writeData,
  input  logic                          writeEnable,
  input  logic                          frameAck,
  output logic                          memWriteEn,
  output logic [addrBits-1:0]           memAddr,
  output logic [messageBits-1:0]        memData,
  output logic [$clog2(imgHeight)-1:0]  row,
  output logic [$clog2(imgWidth)-1:0]   col,
  output logic                          frameDone,
  output logic                          frameFull,
`ifdef FRAME_CHECKSUM_EN
  output logic [messageBits-1:0]        frameChecksum,
`endif
  output logic                          overrunErr
);

  localparam int RowBits = $clog2(imgHeight);
  localparam int ColBits = $clog2(imgWidth);
  localparam logic [RowBits-1:0] RowLast = RowBits'(imgHeight - 1);
  localparam logic [ColBits-1:0] ColLast = ColBits'(imgWidth - 1);

  typedef enum logic [1:0] {IDLE, RECEIVING, FULL} state_e;

  // Synchronizer (s1, s2), edge-detect flop (s3) and the captured byte.
  logic                   s1_q, s2_q, s3_q;
  logic                   byte_strobe;
  logic                   pix_valid_q;
  logic [messageBits-1:0] pix_data_q;

  state_e                 state_q, state_d;
  logic [RowBits-1:0]     row_q, row_d, base_row;
  logic [ColBits-1:0]     col_q, col_d, base_col;
  logic [addrBits-1:0]    addr_q, addr_d, base_addr;
  logic                   we_q, we_d;
  logic [addrBits-1:0]    mem_addr_q, mem_addr_d;
  logic [messageBits-1:0] mem_data_q, mem_data_d;
  logic                   done_pend_q, done_pend_d;
  logic                   frame_done_q;
  logic                   full_q;
  logic                   overrun_q, overrun_d;
  logic [messageBits-1:0] checksum_q, checksum_d;
  logic                   do_write, start_frame;

  // One strobe per writeEnable high level, however long it is held.
  assign byte_strobe = s2_q & ~s3_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    done_pend_d = 1'b0;
    overrun_d   = overrun_q;
    checksum_d  = checksum_q;
    do_write    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_valid_q) begin
          do_write    = 1'b1;
          start_frame = 1'b1;
        end
      end
      RECEIVING: begin
        if (pix_valid_q) do_write = 1'b1;
      end
      FULL: begin
        // The ack wins over a simultaneous byte. The byte then starts the next frame.
        if (pix_valid_q && frameAck) begin
          do_write    = 1'b1;
          start_frame = 1'b1;
        end else if (pix_valid_q) begin
          overrun_d = 1'b1;
        end else if (frameAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame always starts from the origin. Otherwise continue from the
    // current position.
    base_row  = start_frame ? '0 : row_q;
    base_col  = start_frame ? '0 : col_q;
    base_addr = start_frame ? '0 : addr_q;

    if (do_write) begin
      we_d       = 1'b1;
      mem_addr_d = base_addr;
      mem_data_d = pix_data_q;
      state_d    = RECEIVING;
      checksum_d = (base_addr == '0) ? pix_data_q : checksum_q + pix_data_q;
      if (base_col == ColLast) begin
        col_d = '0;
        if (base_row == RowLast) begin
          row_d       = '0;
          addr_d      = '0;
          state_d     = FULL;
          done_pend_d = 1'b1;
        end else begin
          row_d  = base_row + RowBits'(1);
          addr_d = base_addr + addrBits'(1);
        end
      end else begin
        col_d  = base_col + ColBits'(1);
        row_d  = base_row;
        addr_d = base_addr + addrBits'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      checksum_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what makes s1->s2->s3 a pipeline.
      s1_q         <= writeEnable;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pix_valid_q  <= byte_strobe;
      if (byte_strobe) pix_data_q <= writeData;
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= done_pend_q;
      full_q       <= (state_d == FULL);
      overrun_q    <= overrun_d;
      checksum_q   <= checksum_d;
    end
  end

  assign memWriteEn = we_q;
  assign memAddr    = mem_addr_q;
  assign memData    = mem_data_q;
  assign row        = row_q;
  assign col        = col_q;
  assign frameDone  = frame_done_q;
  assign frameFull  = full_q;
  assign overrunErr = overrun_q;
`ifdef FRAME_CHECKSUM_EN
  assign frameChecksum = checksum_q;
`endif

endmodule
